// File: rtl/counter_updown_if.sv
// Control/status bundle for counter_updown.
// Master drives the commands, slave (the counter) returns the count and flags.
interface counter_updown_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] d;
  logic             load;
  logic             enable;
  logic             up;
  logic             clear;
  logic [WIDTH-1:0] q;
  logic             at_min;
  logic             at_max;
  logic             carry;
  logic             ovf;

  modport master (
    output d, load, enable, up, clear,
    input  q, at_min, at_max, carry, ovf
  );

  modport slave (
    input  d, load, enable, up, clear,
    output q, at_min, at_max, carry, ovf
  );
endinterface

// File: rtl/counter_updown.sv
// Up/down counter over [MIN, MAX] with step, wrap/saturate,
// load clamp, one-cycle carry pulse and sticky overflow.
module counter_updown #(
  parameter int WIDTH = 4,
  parameter int MIN   = 0,
  parameter int MAX   = 12,
  parameter int STEP  = 1,
  parameter int WRAP  = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  counter_updown_if.slave bus
);
  localparam int W2 = WIDTH + 2;
  localparam int R  = MAX - MIN + 1;

  localparam logic [W2-1:0] P_MIN  = W2'(MIN);
  localparam logic [W2-1:0] P_MAX  = W2'(MAX);
  localparam logic [W2-1:0] P_STEP = W2'(STEP);
  localparam logic [W2-1:0] P_R    = W2'(R);

  localparam logic [WIDTH-1:0] L_MIN = WIDTH'(MIN);
  localparam logic [WIDTH-1:0] L_MAX = WIDTH'(MAX);

  logic [WIDTH-1:0] r_q;
  logic             r_carry;
  logic             r_ovf;

  logic [WIDTH-1:0] w_q_nxt;
  logic             w_carry_nxt;
  logic             w_ovf_nxt;

  logic [W2-1:0] w_ext;
  logic [W2-1:0] w_d;
  logic [W2-1:0] w_sum;
  logic [W2-1:0] w_dif;
  logic [W2-1:0] w_up_wrap;
  logic [W2-1:0] w_dn_wrap;
  logic          w_over;
  logic          w_under;

  // Two guard bits keep the sum unsigned-exact and the difference signed.
  assign w_ext     = {2'b00, r_q};
  assign w_d       = {2'b00, bus.d};
  assign w_sum     = w_ext + P_STEP;
  assign w_dif     = w_ext - P_STEP;
  assign w_up_wrap = w_sum - P_R;
  assign w_dn_wrap = w_dif + P_R;
  assign w_over    = (w_sum > P_MAX);
  assign w_under   = ($signed(w_dif) < $signed(P_MIN));

  always_comb begin
    w_q_nxt     = r_q;
    w_carry_nxt = 1'b0;
    if (bus.clear) begin
      w_q_nxt = L_MIN;
    end else if (bus.load) begin
      if (w_d > P_MAX)
        w_q_nxt = L_MAX;
      else if (w_d < P_MIN)
        w_q_nxt = L_MIN;
      else
        w_q_nxt = bus.d;
    end else if (bus.enable) begin
      if (bus.up) begin
        if (w_over) begin
          w_carry_nxt = 1'b1;
          w_q_nxt = (WRAP != 0) ? w_up_wrap[WIDTH-1:0] : L_MAX;
        end else begin
          w_q_nxt = w_sum[WIDTH-1:0];
        end
      end else begin
        if (w_under) begin
          w_carry_nxt = 1'b1;
          w_q_nxt = (WRAP != 0) ? w_dn_wrap[WIDTH-1:0] : L_MIN;
        end else begin
          w_q_nxt = w_dif[WIDTH-1:0];
        end
      end
    end
  end

  assign w_ovf_nxt = bus.clear ? 1'b0 : (r_ovf | w_carry_nxt);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q     <= L_MIN;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_q     <= w_q_nxt;
      r_carry <= w_carry_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  assign bus.q      = r_q;
  assign bus.carry  = r_carry;
  assign bus.ovf    = r_ovf;
  assign bus.at_min = (r_q == L_MIN);
  assign bus.at_max = (r_q == L_MAX);
endmodule

// File: tb/tb_counter_updown.sv
// Directed table-driven bench for counter_updown over four
// parameter sets, plus async-reset corner sequences.
module tb_counter_updown;
  logic clk;
  logic rst_n;

  int total = 0;
  int bad   = 0;

  counter_updown_if #(.WIDTH(4)) ifa ();
  counter_updown_if #(.WIDTH(4)) ifb ();
  counter_updown_if #(.WIDTH(4)) ifc ();
  counter_updown_if #(.WIDTH(4)) ifd ();

  counter_updown #(.WIDTH(4), .MIN(0), .MAX(12), .STEP(1), .WRAP(1))
    u_a (.i_clk(clk), .i_rst_n(rst_n), .bus(ifa));
  counter_updown #(.WIDTH(4), .MIN(0), .MAX(12), .STEP(5), .WRAP(1))
    u_b (.i_clk(clk), .i_rst_n(rst_n), .bus(ifb));
  counter_updown #(.WIDTH(4), .MIN(2), .MAX(12), .STEP(1), .WRAP(0))
    u_c (.i_clk(clk), .i_rst_n(rst_n), .bus(ifc));
  counter_updown #(.WIDTH(4), .MIN(0), .MAX(12), .STEP(8), .WRAP(1))
    u_d (.i_clk(clk), .i_rst_n(rst_n), .bus(ifd));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         dut;
    logic       clr;
    logic       ld;
    logic       en;
    logic       u;
    logic [3:0] d;
    logic [3:0] q;
    logic       c;
    logic       o;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(int dut, bit clr, bit ld, bit en, bit u,
                              int d, int q, bit c, bit o);
    vec_t v;
    v.dut = dut; v.clr = clr; v.ld = ld; v.en = en; v.u = u;
    v.d = 4'(d); v.q = 4'(q); v.c = c; v.o = o;
    return v;
  endfunction

  function automatic int min_of(int dut);
    return (dut == 2) ? 2 : 0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic drive(input int dut, input logic clr, input logic ld,
                       input logic en, input logic u, input logic [3:0] dv);
    ifa.d = dv; ifb.d = dv; ifc.d = dv; ifd.d = dv;
    ifa.clear = (dut == 0) & clr; ifa.load = (dut == 0) & ld;
    ifa.enable = (dut == 0) & en; ifa.up = u;
    ifb.clear = (dut == 1) & clr; ifb.load = (dut == 1) & ld;
    ifb.enable = (dut == 1) & en; ifb.up = u;
    ifc.clear = (dut == 2) & clr; ifc.load = (dut == 2) & ld;
    ifc.enable = (dut == 2) & en; ifc.up = u;
    ifd.clear = (dut == 3) & clr; ifd.load = (dut == 3) & ld;
    ifd.enable = (dut == 3) & en; ifd.up = u;
  endtask

  task automatic check_dut(input int dut, input string tag,
                           input logic [3:0] eq, input logic ec,
                           input logic eo);
    logic [3:0] q;
    logic c, o, mn, mx;
    int lo;
    case (dut)
      0: begin q = ifa.q; c = ifa.carry; o = ifa.ovf;
               mn = ifa.at_min; mx = ifa.at_max; end
      1: begin q = ifb.q; c = ifb.carry; o = ifb.ovf;
               mn = ifb.at_min; mx = ifb.at_max; end
      2: begin q = ifc.q; c = ifc.carry; o = ifc.ovf;
               mn = ifc.at_min; mx = ifc.at_max; end
      default: begin q = ifd.q; c = ifd.carry; o = ifd.ovf;
               mn = ifd.at_min; mx = ifd.at_max; end
    endcase
    lo = min_of(dut);
    chk({tag, " q"}, 32'(q), 32'(eq));
    chk({tag, " carry"}, 32'(c), 32'(ec));
    chk({tag, " ovf"}, 32'(o), 32'(eo));
    chk({tag, " at_min"}, 32'(mn), 32'(int'(eq) == lo));
    chk({tag, " at_max"}, 32'(mx), 32'(int'(eq) == 12));
    chk({tag, " range"}, 32'(int'(q) >= lo && int'(q) <= 12), 32'd1);
  endtask

  initial begin
    // A: defaults, count through a wrap, then sticky ovf and clear
    for (int k = 1; k <= 12; k++) tv.push_back(mk(0,0,0,1,1,0, k,0,0));
    tv.push_back(mk(0,0,0,1,1,0, 0,1,1));
    tv.push_back(mk(0,0,0,1,1,0, 1,0,1));
    tv.push_back(mk(0,0,0,1,1,0, 2,0,1));
    for (int k = 3; k <= 7; k++) tv.push_back(mk(0,0,0,1,1,0, k,0,1));
    tv.push_back(mk(0,1,0,0,0,0, 0,0,0));
    tv.push_back(mk(0,0,0,0,0,0, 0,0,0));
    // B: STEP=5 wrap in both directions
    tv.push_back(mk(1,0,1,0,0,10, 10,0,0));
    tv.push_back(mk(1,0,0,1,1,0,   2,1,1));
    tv.push_back(mk(1,0,1,0,0,1,   1,0,1));
    tv.push_back(mk(1,0,0,1,0,0,   9,1,1));
    tv.push_back(mk(1,0,1,0,0,7,   7,0,1));
    tv.push_back(mk(1,0,0,1,0,0,   2,0,1));
    tv.push_back(mk(1,0,0,1,1,0,   7,0,1));
    // C: MIN=2, saturate, clamp and priority
    tv.push_back(mk(2,0,1,0,0,11, 11,0,0));
    tv.push_back(mk(2,0,0,1,1,0,  12,0,0));
    tv.push_back(mk(2,0,0,1,1,0,  12,1,1));
    tv.push_back(mk(2,0,0,1,1,0,  12,1,1));
    tv.push_back(mk(2,0,1,0,0,2,   2,0,1));
    tv.push_back(mk(2,0,0,1,0,0,   2,1,1));
    tv.push_back(mk(2,0,1,1,1,15, 12,0,1));
    tv.push_back(mk(2,0,1,0,0,1,   2,0,1));
    tv.push_back(mk(2,0,1,0,0,9,   9,0,1));
    tv.push_back(mk(2,1,1,1,1,9,   2,0,0));
    tv.push_back(mk(2,0,0,0,0,5,   2,0,0));
    // D: STEP=8, wrap from MAX lands mid-range
    tv.push_back(mk(3,0,1,0,0,12, 12,0,0));
    tv.push_back(mk(3,0,0,1,1,0,   7,1,1));
  end

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 4'd0);
    repeat (2) @(posedge clk);
    #1;
    check_dut(0, "reset a", 4'd0, 1'b0, 1'b0);
    check_dut(2, "reset c", 4'd2, 1'b0, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].dut, tv[i].clr, tv[i].ld, tv[i].en, tv[i].u, tv[i].d);
      @(posedge clk);
      #1;
      check_dut(tv[i].dut, $sformatf("vec%0d", i), tv[i].q, tv[i].c, tv[i].o);
    end

    // Async reset between edges while D shows q=7, carry=1, ovf=1
    drive(3, 0, 0, 1, 1, 4'd0);
    #3;
    rst_n = 1'b0;
    #1;
    check_dut(3, "arst now", 4'd0, 1'b0, 1'b0);
    check_dut(0, "arst a", 4'd0, 1'b0, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
      check_dut(3, "arst hold", 4'd0, 1'b0, 1'b0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_dut(3, "post rst", 4'd8, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
